// File: rtl/ssd_driver.sv
// Four-digit multiplexed seven-segment driver with a sequential double-dabble converter.
// Optional leading-zero blanking when SSD_LEADING_ZERO_BLANK_EN is defined.
module ssd_driver #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        busy
);

    typedef enum logic {StIdle, StConvert} state_e;

    state_e                  state_q, state_d;
    logic [12:0]             last_q, last_d;
    logic [12:0]             shift_q, shift_d;
    logic [15:0]             work_q, work_d, work_adj;
    logic [15:0]             disp_q, disp_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [REFRESH_BITS-1:0] scan_q, scan_d;
    logic [3:0]              anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic [1:0]              sel;
    logic [3:0]              nib;
    logic                    blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_q    <= '0;
            shift_q   <= '0;
            work_q    <= '0;
            disp_q    <= '0;
            cnt_q     <= '0;
            scan_q    <= '0;
            anode_q   <= 4'b1110;
            cathode_q <= 7'b1000000;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            work_q    <= work_d;
            disp_q    <= disp_d;
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shift_d = shift_q;
        work_d  = work_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        scan_d  = scan_q + REFRESH_BITS'(1);
        for (int i = 0; i < 4; i++) begin
            work_adj[4*i +: 4] = (work_q[4*i +: 4] >= 4'd5) ? work_q[4*i +: 4] + 4'd3
                                                             : work_q[4*i +: 4];
        end
        unique case (state_q)
            StIdle: begin
                if (value != last_q) begin
                    last_d  = value;
                    shift_d = value;
                    work_d  = '0;
                    cnt_d   = 4'd12;
                    state_d = StConvert;
                end
            end
            StConvert: begin
                work_d  = {work_adj[14:0], shift_q[12]};
                shift_d = {shift_q[11:0], 1'b0};
                if (cnt_q == 4'd0) begin
                    // Only the finished result ever reaches the display register.
                    disp_d  = work_d;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    // Outputs are registered from next-state values so anode, cathode and display move together.
    always_comb begin
        busy = (state_q == StConvert);
        sel  = scan_d[REFRESH_BITS-1 -: 2];
        nib  = disp_d[4*sel +: 4];
`ifdef SSD_LEADING_ZERO_BLANK_EN
        unique case (sel)
            2'd0: blank = 1'b0;
            2'd1: blank = (disp_d[15:4] == 12'd0);
            2'd2: blank = (disp_d[15:8] == 8'd0);
            2'd3: blank = (disp_d[15:12] == 4'd0);
        endcase
`else
        blank = 1'b0;
`endif
        anode_d = ~(4'b0001 << sel);
        unique case (nib)
            4'd0:    cathode_d = 7'b1000000;
            4'd1:    cathode_d = 7'b1111001;
            4'd2:    cathode_d = 7'b0100100;
            4'd3:    cathode_d = 7'b0110000;
            4'd4:    cathode_d = 7'b0011001;
            4'd5:    cathode_d = 7'b0010010;
            4'd6:    cathode_d = 7'b0000010;
            4'd7:    cathode_d = 7'b1111000;
            4'd8:    cathode_d = 7'b0000000;
            4'd9:    cathode_d = 7'b0010000;
            default: cathode_d = 7'b1111111;
        endcase
        if (blank) begin
            cathode_d = 7'b1111111;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule
